fc_stream_loader: RTL and testbench
===================================

// Module: fc_stream_loader
// PURPOSE
//  Stream-side front end for the 3x3x3 fully-connected stage. Collects a weight vector and a pooled
//  feature vector as byte streams (valid/ready) and packs each into the 216-bit operand buses of
//  the existing FC datapath. Registers the 8-bit FC result and returns it on a valid/ready output.
//  Weights persist across feature vectors; only the feature vector is refilled per result.
// PARAMETERS
//  N_ELEM  27  operand bytes per vector (3 depth x 3 rows x 3 cols)
//  DW      8   operand/result width; datapath is fixed at 8, so only DW=8 is legal
// PORTS
//  clk       in   1    single clock, rising edge
//  rst_n     in   1    asynchronous active-low reset
//  wt_valid  in   1    weight byte offered
//  wt_ready  out  1    weight byte accepted when wt_valid&wt_ready
//  wt_data   in   8    signed weight byte
//  px_valid  in   1    pooled feature byte offered
//  px_ready  out  1    feature byte accepted when px_valid&px_ready
//  px_data   in   8    signed pooled feature byte
//  res_valid out  1    result available
//  res_ready in   1    result consumed when res_valid&res_ready
//  res_data  out  8    signed FC result
//  wt_loaded out  1    full weight vector held
// BEHAVIOUR
//  Reset (async, rst_n=0): state=FILL, px_cnt=0, wt_cnt=0, wt_loaded=0, res_valid=0, res_data=0.
//  Operand registers are not reset.
//  Byte k of each stream is written to lin[k*8 +: 8], k = d*9 + r*3 + c, in arrival order 0..26.
//  FSM states: FILL -> CALC -> OUT -> FILL.
//   FILL
//    - px_ready = (px_cnt<N_ELEM); wt_ready = 1.
//    - Each weight accept writes slot wt_cnt.
//    - When wt_cnt==26 is written: wt_cnt wraps to 0 and wt_loaded sets.
//    - Any weight accept while wt_loaded=1 clears wt_loaded, i.e. a reload restarts at slot 0.
//    - px and wt accepts may occur in the same cycle and are independent.
//    - Leave to CALC when px_cnt==N_ELEM && wt_loaded && no weight accept this cycle.
//   CALC
//    - One cycle. px_ready=wt_ready=0.
//    - res_data <= datapath output; res_valid <= 1; go to OUT.
//   OUT
//    - px_ready=wt_ready=0; res_valid held and res_data stable until res_ready.
//    - On handshake: res_valid<=0, px_cnt<=0, go to FILL (accepts resume next cycle).
//  Latency: the last required accept (27th px or 27th wt byte) at edge t gives res_valid=1 after edge t+2.
//  Throughput: one result per 27 px bytes + 3 cycles when res_ready is held high.
//  Operands are frozen outside FILL, so the combinational datapath output is stable when captured.
//  Arithmetic (inside datapath):
//   - 27 signed 8x8 products, sign-extended to 21 bits and summed.
//   - Result is sum[20:8], signed-saturated to 8 bits: arithmetic >>8 clamped to [-128,127].
//  Boundaries:
//   - px bytes beyond 27 are back-pressured (px_ready=0); no overwrite.
//   - A full px vector with wt_loaded=0 waits in FILL indefinitely.
//   - Reset mid-CALC/OUT drops the result; the weight vector must be reloaded.
// STRUCTURE
//  Package fc_pkg holds: N_ELEM=27, DW=8, LIN_W=N_ELEM*DW=216, and the state enum {FILL,CALC,OUT}
//  (2-bit encoding).
//  One generic sub-module, fc_byte_collector, is instantiated twice (weights, features). It
//  provides a write-enable, a 5-bit slot counter with wrap, and a LIN_W-bit register bank.
//  The existing FC datapath connect_module is instantiated once, fed from the two banks.
//  The FSM and the result register live in this module.
// TESTING
//  1 Reset then load 27 wt=0x10 and 27 px=0x10 -> res_data=0x1B (6912>>8=27), res_valid 2 cycles
//    after the last accept.
//  2 Weights 0xF0 (-16), px 0x10 -> res_data=0xE5 (-27). All px 0x01, wt 0x01 -> res_data=0x00.
//  3 wt=px=0x7F -> 0x7F (saturate high). wt=0x80, px=0x7F -> 0x80 (saturate low).
//  4 Hold res_ready=0 for 10 cycles -> res_valid/res_data stable, px_ready=0, wt_ready=0.
//    Then a second px vector with the same weights gives an identical result without a weight reload.
//  5 Interleave px/wt bytes with random valid gaps, including 28 px bytes offered -> 28th stalls,
//    result equals the golden dot product.
//  6 Assert rst_n low during OUT -> res_valid=0 and wt_loaded=0 immediately; a new full load
//    yields a correct result.

Source files
------------

// File: rtl/fc_stream_loader_pkg.sv
// fc_pkg: shared sizes, FSM encoding and result saturation for the FC stream loader
package fc_pkg;
    localparam int N_ELEM = 27;
    localparam int DW     = 8;
    localparam int LIN_W  = N_ELEM * DW;
    localparam int CNT_W  = 5;
    localparam int ACC_W  = 21;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } fc_state_e;

    // Clamp the 13-bit shifted sum into the signed 8-bit result range.
    function automatic logic [DW-1:0] sat8(input logic signed [ACC_W-9:0] v);
        return (v > 13'sd127) ? 8'h7f : (v < -13'sd128) ? 8'h80 : v[DW-1:0];
    endfunction
endpackage

// File: rtl/fc_stream_loader_if.sv
// fc_stream_loader_if: weight/feature input streams, result stream and load status
interface fc_stream_loader_if;
    import fc_pkg::*;
    logic          wt_valid;
    logic          wt_ready;
    logic [DW-1:0] wt_data;
    logic          px_valid;
    logic          px_ready;
    logic [DW-1:0] px_data;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic          wt_loaded;

    modport master (
        output wt_valid, wt_data, px_valid, px_data, res_ready,
        input  wt_ready, px_ready, res_valid, res_data, wt_loaded
    );

    modport slave (
        input  wt_valid, wt_data, px_valid, px_data, res_ready,
        output wt_ready, px_ready, res_valid, res_data, wt_loaded
    );
endinterface

// File: rtl/fc_stream_loader_collector.sv
// fc_byte_collector: packs an accepted byte stream into a linear operand bank by slot counter
module fc_byte_collector
    import fc_pkg::*;
#(
    parameter bit WRAP = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic [DW-1:0]    data_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [LIN_W-1:0] bank_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LIN_W-1:0] bank_q;
    logic             last;

    assign last = cnt_q == CNT_W'(N_ELEM - 1);

    // Next slot: clear wins, wrapping collectors return to slot 0 after the last byte.
    always_comb begin
        cnt_d = clr_i ? '0 : !we_i ? cnt_q : (WRAP && last) ? '0 : cnt_q + 1'b1;
    end

    // Slot counter with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Operand bank, deliberately unreset: contents are only meaningful once a vector is complete.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_ELEM; k++)
            if (we_i && cnt_q == CNT_W'(k)) bank_q[k*DW +: DW] <= data_i;
    end

    assign cnt_o  = cnt_q;
    assign bank_o = bank_q;
endmodule

// File: rtl/fc_stream_loader_datapath.sv
// connect_module: 27-term signed dot product, result = saturate(sum >>> 8)
module connect_module
    import fc_pkg::*;
(
    input  logic [LIN_W-1:0] wt_lin_i,
    input  logic [LIN_W-1:0] px_lin_i,
    output logic [DW-1:0]    res_o
);
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] wa;
    logic signed [ACC_W-1:0] xa;

    // Sign-extend each byte pair to the accumulator width; 27 full-scale products still fit in 21 bits.
    always_comb begin
        sum = '0;
        wa  = '0;
        xa  = '0;
        for (int k = 0; k < N_ELEM; k++) begin
            wa  = {{(ACC_W-DW){wt_lin_i[k*DW+DW-1]}}, wt_lin_i[k*DW +: DW]};
            xa  = {{(ACC_W-DW){px_lin_i[k*DW+DW-1]}}, px_lin_i[k*DW +: DW]};
            sum = sum + wa * xa;
        end
    end

    assign res_o = sat8(sum[ACC_W-1:8]);
endmodule

// File: rtl/fc_stream_loader.sv
// fc_stream_loader: collects weight/feature byte streams, runs the FC datapath, returns one result
module fc_stream_loader
    import fc_pkg::*;
(
    input logic                clk,
    input logic                rst_n,
    fc_stream_loader_if.slave  bus
);
    localparam logic [1:0] FILL = ST_FILL;
    localparam logic [1:0] CALC = ST_CALC;
    localparam logic [1:0] OUT  = ST_OUT;

    logic [1:0]       state_q, state_d;
    logic             wt_loaded_q, wt_loaded_d;
    logic             res_valid_q, res_valid_d;
    logic [DW-1:0]    res_data_q, res_data_d;
    logic             px_acc, wt_acc, res_hs, go_calc;
    logic [CNT_W-1:0] px_cnt, wt_cnt;
    logic [LIN_W-1:0] wt_lin, px_lin;
    logic [DW-1:0]    dp_res;

    assign bus.px_ready = state_q == FILL && px_cnt < CNT_W'(N_ELEM);
    assign bus.wt_ready = state_q == FILL;
    assign px_acc       = bus.px_valid & bus.px_ready;
    assign wt_acc       = bus.wt_valid & bus.wt_ready;
    assign res_hs       = res_valid_q & bus.res_ready;
    assign go_calc      = px_cnt == CNT_W'(N_ELEM) && wt_loaded_q && !wt_acc;

    fc_byte_collector #(.WRAP(1'b1)) u_wt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (1'b0),
        .we_i   (wt_acc),
        .data_i (bus.wt_data),
        .cnt_o  (wt_cnt),
        .bank_o (wt_lin)
    );

    fc_byte_collector #(.WRAP(1'b0)) u_px (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (res_hs),
        .we_i   (px_acc),
        .data_i (bus.px_data),
        .cnt_o  (px_cnt),
        .bank_o (px_lin)
    );

    connect_module u_dp (
        .wt_lin_i (wt_lin),
        .px_lin_i (px_lin),
        .res_o    (dp_res)
    );

    // FSM next state, weight-complete flag and result register updates.
    always_comb begin
        state_d     = state_q == CALC ? OUT : state_q == OUT ? (res_hs ? FILL : OUT) : (go_calc ? CALC : FILL);
        wt_loaded_d = wt_acc ? wt_cnt == CNT_W'(N_ELEM - 1) : wt_loaded_q;
        res_valid_d = state_q == CALC ? 1'b1 : res_hs ? 1'b0 : res_valid_q;
        res_data_d  = state_q == CALC ? dp_res : res_data_q;
    end

    // Control and result state with asynchronous reset; a reset discards any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            wt_loaded_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wt_loaded_q <= wt_loaded_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.wt_loaded = wt_loaded_q;
endmodule

// File: tb/tb_fc_stream_loader.sv
// tb_fc_stream_loader: directed streams against a dot-product model of the FC stream loader
module tb_fc_stream_loader;
    import fc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fc_stream_loader_if bus();

    fc_stream_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int  n_chk = 0;
    int  n_fail = 0;
    byte m_w[27];
    byte m_px[27];
    int  m_pc = 0;
    int  m_wc = 0;
    bit  m_wl = 1'b0;
    byte tw[27];
    byte tp[27];
    logic [7:0] d, d_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int golden();
        int s = 0;
        for (int k = 0; k < 27; k++) s += int'(m_w[k]) * int'(m_px[k]);
        s = s >>> 8;
        return s > 127 ? 127 : s < -128 ? -128 : s;
    endfunction

    // Model tracks accepted bytes; outputs are checked every cycle, then this cycle's handshakes are applied.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_pc = 0;
            m_wc = 0;
            m_wl = 1'b0;
            chk("rst_res_valid", 32'(bus.res_valid), 0);
            chk("rst_wt_loaded", 32'(bus.wt_loaded), 0);
        end else begin
            chk("wt_loaded", 32'(bus.wt_loaded), 32'(m_wl));
            if (m_pc == 27) chk("px_stall", 32'(bus.px_ready), 0);
            if (m_pc < 27 || !m_wl) chk("no_early_res", 32'(bus.res_valid), 0);
            if (bus.res_valid) begin
                chk("res_data", 32'(bus.res_data), 32'(golden() & 255));
                chk("res_blocks_in", 32'({bus.px_ready, bus.wt_ready}), 0);
            end
            if (bus.res_valid && bus.res_ready) m_pc = 0;
            if (bus.px_valid && bus.px_ready && m_pc < 27) begin
                m_px[m_pc] = byte'(bus.px_data);
                m_pc++;
            end
            if (bus.wt_valid && bus.wt_ready) begin
                if (m_wl) begin
                    m_wl = 1'b0;
                    m_wc = 0;
                end
                m_w[m_wc] = byte'(bus.wt_data);
                m_wc++;
                if (m_wc == 27) begin
                    m_wl = 1'b1;
                    m_wc = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input byte wv, input byte pv);
        for (int k = 0; k < 27; k++) begin
            tw[k] = wv;
            tp[k] = pv;
        end
    endtask

    task automatic send(input int nw, input int np, input bit gap);
        int wi = 0;
        int pi = 0;
        int cyc = 0;
        while ((wi < nw || pi < np) && cyc < 500) begin
            bus.wt_valid = wi < nw && (!gap || wi == 0 || $urandom_range(0, 2) != 0);
            bus.wt_data  = tw[wi % 27];
            bus.px_valid = pi < np && (!gap || $urandom_range(0, 2) != 0);
            bus.px_data  = tp[pi % 27];
            @(negedge clk);
            if (bus.wt_valid && bus.wt_ready) wi++;
            if (bus.px_valid && bus.px_ready) pi++;
            tick();
            cyc++;
        end
        bus.wt_valid = 1'b0;
        bus.px_valid = 1'b0;
        chk("send_done", 32'(wi == nw && pi == np), 1);
    endtask

    task automatic wait_res();
        int cyc = 0;
        while (!bus.res_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("res_wait", 32'(bus.res_valid), 1);
    endtask

    task automatic get_res(input int stall, output logic [7:0] r);
        wait_res();
        r = bus.res_data;
        repeat (stall) begin
            tick();
            chk("hold_valid", 32'(bus.res_valid), 1);
            chk("hold_data", 32'(bus.res_data), 32'(r));
            chk("hold_rdy", 32'({bus.px_ready, bus.wt_ready}), 0);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic latency(input string name);
        chk({name, "_lat0"}, 32'(bus.res_valid), 0);
        tick();
        chk({name, "_lat1"}, 32'(bus.res_valid), 0);
        tick();
        chk({name, "_lat2"}, 32'(bus.res_valid), 1);
    endtask

    initial begin
        bus.wt_valid  = 1'b0;
        bus.wt_data   = '0;
        bus.px_valid  = 1'b0;
        bus.px_data   = '0;
        bus.res_ready = 1'b0;
        repeat (2) tick();
        chk("reset_res_valid", 32'(bus.res_valid), 0);
        chk("reset_res_data", 32'(bus.res_data), 0);
        chk("reset_wt_loaded", 32'(bus.wt_loaded), 0);
        chk("reset_readies", 32'({bus.px_ready, bus.wt_ready}), 2'b11);
        rst_n = 1'b1;
        tick();

        fill(8'sh10, 8'sh10);
        send(27, 0, 1'b0);
        chk("t1_wt_loaded", 32'(bus.wt_loaded), 1);
        send(0, 27, 1'b0);
        latency("t1");
        get_res(0, d);
        chk("t1_res", 32'(d), 32'h1b);

        fill(8'shf0, 8'sh10);
        send(27, 27, 1'b0);
        get_res(0, d);
        chk("t2_neg_res", 32'(d), 32'he5);
        fill(8'sh01, 8'sh01);
        send(27, 27, 1'b0);
        get_res(0, d);
        chk("t2_small_res", 32'(d), 32'h00);

        fill(8'sh7f, 8'sh7f);
        send(27, 27, 1'b0);
        get_res(0, d);
        chk("t3_sat_hi", 32'(d), 32'h7f);
        fill(8'sh80, 8'sh7f);
        send(27, 27, 1'b0);
        get_res(10, d);
        chk("t3_sat_lo", 32'(d), 32'h80);
        d_prev = d;
        send(0, 27, 1'b0);
        get_res(0, d);
        chk("t4_reuse_wt", 32'(d), 32'(d_prev));

        for (int k = 0; k < 27; k++) begin
            tw[k] = byte'(k * 37 - 100);
            tp[k] = byte'(60 - k * 9);
        end
        send(27, 27, 1'b1);
        bus.px_valid = 1'b1;
        bus.px_data  = 8'h55;
        repeat (2) begin
            @(negedge clk);
            chk("t5_px28_stall", 32'(bus.px_ready), 0);
            tick();
        end
        get_res(2, d);
        chk("t5_res", 32'(d), 32'(golden() & 255));
        tick();
        bus.px_valid = 1'b0;

        for (int k = 0; k < 26; k++) tp[k] = byte'(k * 5 - 40);
        send(0, 26, 1'b0);
        wait_res();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_res_valid", 32'(bus.res_valid), 0);
        chk("t6_rst_wt_loaded", 32'(bus.wt_loaded), 0);
        tick();
        rst_n = 1'b1;
        tick();
        fill(8'sh02, 8'shfd);
        send(0, 27, 1'b0);
        repeat (5) begin
            chk("t6_wait_wt", 32'(bus.res_valid | bus.px_ready), 0);
            tick();
        end
        send(27, 0, 1'b0);
        latency("t6");
        get_res(0, d);
        chk("t6_res", 32'(d), 32'hff);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
